// File: rtl/sprite_write_sched.sv
// Sprite engine write scheduler: arbitrates CPU writes against a small
// deferred-update FIFO that is only drained while vblank is high.
module sprite_write_sched #(
   parameter int QDEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic [5:0]  cpu_addr,
   input  logic [15:0] cpu_data,
   output logic        cpu_ack,
   input  logic        q_push,
   input  logic [5:0]  q_addr,
   input  logic [15:0] q_data,
   output logic        q_full,
   output logic [2:0]  q_count,
   input  logic        vblank,
   input  logic        clr_ovf,
   output logic        eng_wr,
   output logic [5:0]  eng_addr,
   output logic [15:0] eng_data,
   output logic        done,
   output logic        ovf
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam logic [2:0] QD = 3'(QDEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [5:0]    addr_mem [QDEPTH];
   logic [15:0]   data_mem [QDEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [2:0]    count_q, count_d;
   logic          full_q, full_d;
   logic          ovf_q, ovf_d;
   logic          eng_wr_q, eng_wr_d;
   logic [5:0]    eng_addr_q, eng_addr_d;
   logic [15:0]   eng_data_q, eng_data_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic          done_q, done_d;

   logic          push_ok;
   logic          q_win;
   logic          cpu_win;

   // Push acceptance depends only on the registered full flag, so a
   // same-cycle pop never rescues a push made while full.
   always_comb begin
      push_ok = q_push && !full_q;
      q_win   = (state_q == DRAIN) && vblank && (count_q != 3'd0);
      cpu_win = cpu_req && !q_win;
   end

   // Next-state, pointer, counter and output-register logic.
   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      eng_wr_d   = 1'b0;
      eng_addr_d = eng_addr_q;
      eng_data_d = eng_data_q;
      cpu_ack_d  = 1'b0;
      done_d     = 1'b0;

      if (push_ok) begin
         wptr_d = wptr_q + 1'b1;
      end

      if (q_win) begin
         rptr_d = rptr_q + 1'b1;
      end

      count_d = count_q + {2'b00, push_ok} - {2'b00, q_win};

      if (q_push && full_q) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end

      unique case (1'b1)
         q_win: begin
            eng_wr_d   = 1'b1;
            eng_addr_d = addr_mem[rptr_q];
            eng_data_d = data_mem[rptr_q];
         end
         cpu_win: begin
            eng_wr_d   = 1'b1;
            eng_addr_d = cpu_addr;
            eng_data_d = cpu_data;
            cpu_ack_d  = 1'b1;
         end
         default: begin
         end
      endcase

      unique case (state_q)
         IDLE: begin
            if (vblank && (count_q != 3'd0)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!vblank || (count_q == 3'd0)) begin
               state_d = IDLE;
            end else if (count_d == 3'd0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      full_d = (count_d == QD);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= 3'd0;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         eng_wr_q   <= 1'b0;
         eng_addr_q <= 6'd0;
         eng_data_q <= 16'd0;
         cpu_ack_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
         ovf_q      <= ovf_d;
         eng_wr_q   <= eng_wr_d;
         eng_addr_q <= eng_addr_d;
         eng_data_q <= eng_data_d;
         cpu_ack_q  <= cpu_ack_d;
         done_q     <= done_d;
      end
   end

   // FIFO storage; contents need no reset since pointers gate validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         addr_mem[wptr_q] <= q_addr;
         data_mem[wptr_q] <= q_data;
      end
   end

   assign cpu_ack  = cpu_ack_q;
   assign q_full   = full_q;
   assign q_count  = count_q;
   assign eng_wr   = eng_wr_q;
   assign eng_addr = eng_addr_q;
   assign eng_data = eng_data_q;
   assign done     = done_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_sprite_write_sched.sv
// Directed bench for sprite_write_sched.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sprite_write_sched;

   logic        clk;
   logic        rst_n;
   logic        cpu_req;
   logic [5:0]  cpu_addr;
   logic [15:0] cpu_data;
   logic        cpu_ack;
   logic        q_push;
   logic [5:0]  q_addr;
   logic [15:0] q_data;
   logic        q_full;
   logic [2:0]  q_count;
   logic        vblank;
   logic        clr_ovf;
   logic        eng_wr;
   logic [5:0]  eng_addr;
   logic [15:0] eng_data;
   logic        done;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   sprite_write_sched #(.QDEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .cpu_ack(cpu_ack),
      .q_push(q_push), .q_addr(q_addr), .q_data(q_data),
      .q_full(q_full), .q_count(q_count),
      .vblank(vblank), .clr_ovf(clr_ovf),
      .eng_wr(eng_wr), .eng_addr(eng_addr), .eng_data(eng_data),
      .done(done), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] a, input logic [15:0] d);
      q_push = 1'b1; q_addr = a; q_data = d;
      step();
      q_push = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", q_count); end
      checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL rst_full got=%0b exp=0", q_full); end
      checks++; if (eng_wr !== 1'b0 || cpu_ack !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_pulses got=%0b%0b%0b exp=000", eng_wr, cpu_ack, done); end
      checks++; if (eng_addr !== 6'd0 || eng_data !== 16'd0) begin errors++; $display("FAIL rst_bus got=%h/%h exp=00/0000", eng_addr, eng_data); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%0b exp=0", ovf); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_drain_basic();
      vblank = 1'b0;
      push(6'h04, 16'h1020);
      push(6'h1A, 16'h3040);
      checks++; if (q_count !== 3'd2) begin errors++; $display("FAIL basic_count got=%0d exp=2", q_count); end
      vblank = 1'b1;
      step();
      checks++; if (eng_wr !== 1'b0) begin errors++; $display("FAIL basic_idle_edge got=%0b exp=0", eng_wr); end
      step();
      checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h04 || eng_data !== 16'h1020 || done !== 1'b0) begin errors++; $display("FAIL basic_w1 got=%0b %h %h d%0b exp=1 04 1020 d0", eng_wr, eng_addr, eng_data, done); end
      step();
      checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h1A || eng_data !== 16'h3040 || done !== 1'b1) begin errors++; $display("FAIL basic_w2 got=%0b %h %h d%0b exp=1 1a 3040 d1", eng_wr, eng_addr, eng_data, done); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL basic_empty got=%0d exp=0", q_count); end
      vblank = 1'b0;
      step();
      checks++; if (eng_wr !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL basic_deassert got=%0b%0b exp=00", eng_wr, done); end
   endtask

   task automatic test_cpu();
      vblank = 1'b0;
      cpu_req = 1'b1; cpu_addr = 6'h06; cpu_data = 16'hBEEF;
      step();
      checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h06 || eng_data !== 16'hBEEF || cpu_ack !== 1'b1) begin errors++; $display("FAIL cpu_grant got=%0b %h %h a%0b exp=1 06 beef a1", eng_wr, eng_addr, eng_data, cpu_ack); end
      cpu_req = 1'b0;
      step();
      checks++; if (eng_wr !== 1'b0 || cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_deassert got=%0b%0b exp=00", eng_wr, cpu_ack); end
   endtask

   task automatic test_arbitration();
      logic [5:0] ea [3] = '{6'h11, 6'h12, 6'h13};
      vblank = 1'b0;
      for (int i = 0; i < 3; i++) push(ea[i], 16'hA000 + 16'(i));
      vblank = 1'b1;
      step();
      cpu_req = 1'b1; cpu_addr = 6'h2A; cpu_data = 16'hCAFE;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (eng_wr !== 1'b1 || eng_addr !== ea[i] || eng_data !== 16'hA000 + 16'(i) || cpu_ack !== 1'b0) begin errors++; $display("FAIL arb_q%0d got=%0b %h %h a%0b exp=1 %h %h a0", i, eng_wr, eng_addr, eng_data, cpu_ack, ea[i], 16'hA000 + 16'(i)); end
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL arb_done got=%0b exp=1", done); end
      step();
      checks++; if (eng_wr !== 1'b1 || cpu_ack !== 1'b1 || eng_addr !== 6'h2A || eng_data !== 16'hCAFE) begin errors++; $display("FAIL arb_cpu got=%0b a%0b %h %h exp=1 a1 2a cafe", eng_wr, cpu_ack, eng_addr, eng_data); end
      cpu_req = 1'b0; vblank = 1'b0;
      step();
   endtask

   task automatic test_overflow();
      vblank = 1'b0;
      for (int i = 0; i < 4; i++) push(6'h10 + 6'(i), 16'h5000 + 16'(i));
      checks++; if (q_full !== 1'b1 || q_count !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_fill got=f%0b c%0d o%0b exp=f1 c4 o0", q_full, q_count, ovf); end
      push(6'h3F, 16'hDEAD);
      checks++; if (q_full !== 1'b1 || q_count !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_drop got=f%0b c%0d o%0b exp=f1 c4 o1", q_full, q_count, ovf); end
      clr_ovf = 1'b1;
      push(6'h3E, 16'hBAD0);
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_clr_collide got=%0b exp=1", ovf); end
      step();
      clr_ovf = 1'b0;
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", ovf); end
      vblank = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h10 + 6'(i) || eng_data !== 16'h5000 + 16'(i)) begin errors++; $display("FAIL ovf_drain%0d got=%0b %h %h exp=1 %h %h", i, eng_wr, eng_addr, eng_data, 6'h10 + 6'(i), 16'h5000 + 16'(i)); end
      end
      checks++; if (done !== 1'b1 || q_full !== 1'b0) begin errors++; $display("FAIL ovf_done got=d%0b f%0b exp=d1 f0", done, q_full); end
      step();
      checks++; if (eng_wr !== 1'b0) begin errors++; $display("FAIL ovf_no5th got=%0b exp=0", eng_wr); end
      vblank = 1'b0;
      step();
   endtask

   task automatic test_vblank_drop();
      vblank = 1'b0;
      for (int i = 0; i < 4; i++) push(6'h20 + 6'(i), 16'h6000 + 16'(i));
      vblank = 1'b1;
      step();
      step();
      step();
      checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h21 || q_count !== 3'd2) begin errors++; $display("FAIL vbd_pop2 got=%0b %h c%0d exp=1 21 c2", eng_wr, eng_addr, q_count); end
      vblank = 1'b0;
      step();
      checks++; if (eng_wr !== 1'b0 || done !== 1'b0 || q_count !== 3'd2) begin errors++; $display("FAIL vbd_stop got=%0b d%0b c%0d exp=0 d0 c2", eng_wr, done, q_count); end
      step();
      vblank = 1'b1;
      step();
      checks++; if (eng_wr !== 1'b0) begin errors++; $display("FAIL vbd_idle_edge got=%0b exp=0", eng_wr); end
      step();
      checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h22 || eng_data !== 16'h6002 || done !== 1'b0) begin errors++; $display("FAIL vbd_r1 got=%0b %h %h d%0b exp=1 22 6002 d0", eng_wr, eng_addr, eng_data, done); end
      step();
      checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h23 || eng_data !== 16'h6003 || done !== 1'b1 || q_count !== 3'd0) begin errors++; $display("FAIL vbd_r2 got=%0b %h %h d%0b c%0d exp=1 23 6003 d1 c0", eng_wr, eng_addr, eng_data, done, q_count); end
      vblank = 1'b0;
      step();
   endtask

   task automatic test_push_during_drain();
      vblank = 1'b0;
      push(6'h30, 16'h7000);
      push(6'h31, 16'h7001);
      vblank = 1'b1;
      step();
      push(6'h32, 16'h7002);
      checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h30 || q_count !== 3'd2) begin errors++; $display("FAIL pdd_pushpop got=%0b %h c%0d exp=1 30 c2", eng_wr, eng_addr, q_count); end
      step();
      checks++; if (eng_addr !== 6'h31 || done !== 1'b0) begin errors++; $display("FAIL pdd_r2 got=%h d%0b exp=31 d0", eng_addr, done); end
      step();
      checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h32 || eng_data !== 16'h7002 || done !== 1'b1) begin errors++; $display("FAIL pdd_r3 got=%0b %h %h d%0b exp=1 32 7002 d1", eng_wr, eng_addr, eng_data, done); end
      vblank = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_drain();
      vblank = 1'b0;
      for (int i = 0; i < 3; i++) push(6'h08 + 6'(i), 16'h9000 + 16'(i));
      vblank = 1'b1;
      step();
      step();
      rst_n = 1'b0;
      step();
      checks++; if (q_count !== 3'd0 || eng_wr !== 1'b0 || ovf !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmd_reset got=c%0d w%0b o%0b d%0b exp=c0 w0 o0 d0", q_count, eng_wr, ovf, done); end
      rst_n = 1'b1;
      step();
      checks++; if (eng_wr !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL rmd_after got=w%0b c%0d exp=w0 c0", eng_wr, q_count); end
      push(6'h0F, 16'h1234);
      checks++; if (eng_wr !== 1'b0 || q_count !== 3'd1) begin errors++; $display("FAIL rmd_push got=w%0b c%0d exp=w0 c1", eng_wr, q_count); end
      step();
      checks++; if (eng_wr !== 1'b0) begin errors++; $display("FAIL rmd_idle_edge got=%0b exp=0", eng_wr); end
      step();
      checks++; if (eng_wr !== 1'b1 || eng_addr !== 6'h0F || eng_data !== 16'h1234 || done !== 1'b1) begin errors++; $display("FAIL rmd_drain got=%0b %h %h d%0b exp=1 0f 1234 d1", eng_wr, eng_addr, eng_data, done); end
      vblank = 1'b0;
      step();
   endtask

   initial begin
      rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
      q_push = 1'b0; q_addr = '0; q_data = '0;
      vblank = 1'b0; clr_ovf = 1'b0;
      test_reset();
      test_drain_basic();
      test_cpu();
      test_arbitration();
      test_overflow();
      test_vblank_drop();
      test_push_during_drain();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
